// File: rtl/eight_queen_pkg.sv
// Purpose: shared constants and types for the eight-queens solver/checker pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: board size, diagonal mask width, err_code values, checker FSM
// state encoding, and a saturating 8-bit increment helper.
package eight_queen_pkg;

  localparam int ROWS   = 8;
  localparam int DIAG_W = 2 * ROWS - 1;  // 15 diagonals in each direction

  localparam logic [2:0] EQ_OK          = 3'd0;
  localparam logic [2:0] EQ_NOT_ONE_HOT = 3'd1;
  localparam logic [2:0] EQ_COLUMN      = 3'd2;
  localparam logic [2:0] EQ_DIAGONAL    = 3'd3;
  localparam logic [2:0] EQ_FRAGMENT    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } eq_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/eight_queen_checker_onehot.sv
// Purpose: 8-bit one-hot detector and 8->3 index encoder.
// Latency: combinational.
// Backpressure: none.
// Ports: bus (row byte in), is_onehot (exactly one bit set), idx (set-bit
// index; highest set bit when not one-hot, 0 when bus is zero).
module onehot_encode8 (
  input  logic [7:0] bus,
  output logic       is_onehot,
  output logic [2:0] idx
);

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus[i]) idx = i[2:0];
    end
    // Clearing the lowest set bit leaves zero only for a single set bit.
    is_onehot = (bus != 8'd0) && ((bus & (bus - 8'd1)) == 8'd0);
  end

endmodule

// File: rtl/eight_queen_checker.sv
// Purpose: collects 8 one-hot row bytes per board and checks them as a legal 8-queens placement.
// Latency: verdict pulses on check_valid one cycle after the state following the last row (REPORT).
// Backpressure: none; a row is consumed on every cycle done is high, including the REPORT cycle.
// Ports: clk, user_reset (async, active high), done/out_bus (row stream),
// check_valid/check_ok/err_code/err_row (registered verdict, held until the next
// report), busy (board partially collected), board_count/pass_count (saturating).
module eight_queen_checker
  import eight_queen_pkg::*;
#(
  parameter int ROWS = 8
) (
  input  logic            clk,
  input  logic            user_reset,
  input  logic            done,
  input  logic [ROWS-1:0] out_bus,
  output logic            check_valid,
  output logic            check_ok,
  output logic [2:0]      err_code,
  output logic [2:0]      err_row,
  output logic            busy,
  output logic [7:0]      board_count,
  output logic [7:0]      pass_count
);

  eq_state_t         state;
  logic [2:0]        row_cnt;
  logic [ROWS-1:0]   col_mask;
  logic [DIAG_W-1:0] d1_mask;
  logic [DIAG_W-1:0] d2_mask;
  logic [2:0]        err_q;
  logic [2:0]        err_row_q;

  logic              is_onehot;
  logic [2:0]        col;

  onehot_encode8 u_onehot (
    .bus       (out_bus),
    .is_onehot (is_onehot),
    .idx       (col)
  );

  // Per-row check. Outside COLLECT the incoming row is row 0 of a fresh board,
  // so it is checked against empty masks and a clear sticky error; this lets
  // the REPORT cycle accept the next board's first row.
  logic              fresh;
  logic [2:0]        row_idx;
  logic [3:0]        d1_idx;
  logic [3:0]        d2_idx;
  logic [ROWS-1:0]   col_cur;
  logic [DIAG_W-1:0] d1_cur;
  logic [DIAG_W-1:0] d2_cur;
  logic [2:0]        err_cur;
  logic [2:0]        err_row_cur;
  logic [2:0]        row_code;
  logic [ROWS-1:0]   col_next;
  logic [DIAG_W-1:0] d1_next;
  logic [DIAG_W-1:0] d2_next;
  logic [2:0]        err_next;
  logic [2:0]        err_row_next;

  always_comb begin
    fresh       = (state != ST_COLLECT);
    row_idx     = fresh ? 3'd0 : row_cnt;
    col_cur     = fresh ? '0 : col_mask;
    d1_cur      = fresh ? '0 : d1_mask;
    d2_cur      = fresh ? '0 : d2_mask;
    err_cur     = fresh ? EQ_OK : err_q;
    err_row_cur = fresh ? 3'd0 : err_row_q;

    // r+c spans 0..14, r-c+7 spans 0..14: both fit 4 bits without wrap.
    d1_idx = {1'b0, row_idx} + {1'b0, col};
    d2_idx = {1'b0, row_idx} - {1'b0, col} + 4'd7;

    row_code = EQ_OK;
    if (!is_onehot) begin
      row_code = EQ_NOT_ONE_HOT;
    end else if (col_cur[col]) begin
      row_code = EQ_COLUMN;
    end else if (d1_cur[d1_idx] || d2_cur[d2_idx]) begin
      row_code = EQ_DIAGONAL;
    end

    // Any one-hot row claims its column and diagonals, even if it collided.
    col_next = col_cur;
    d1_next  = d1_cur;
    d2_next  = d2_cur;
    if (is_onehot) begin
      col_next = col_cur | (ROWS'(1) << col);
      d1_next  = d1_cur | (DIAG_W'(1) << d1_idx);
      d2_next  = d2_cur | (DIAG_W'(1) << d2_idx);
    end

    // Only the first error of a board is kept.
    err_next     = err_cur;
    err_row_next = err_row_cur;
    if (err_cur == EQ_OK && row_code != EQ_OK) begin
      err_next     = row_code;
      err_row_next = row_idx;
    end
  end

  assign busy = (state == ST_COLLECT);

  always_ff @(posedge clk or posedge user_reset) begin
    if (user_reset) begin
      state       <= ST_IDLE;
      row_cnt     <= 3'd0;
      col_mask    <= '0;
      d1_mask     <= '0;
      d2_mask     <= '0;
      err_q       <= EQ_OK;
      err_row_q   <= 3'd0;
      check_valid <= 1'b0;
      check_ok    <= 1'b0;
      err_code    <= EQ_OK;
      err_row     <= 3'd0;
      board_count <= 8'd0;
      pass_count  <= 8'd0;
    end else begin
      check_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (done) begin
            col_mask  <= col_next;
            d1_mask   <= d1_next;
            d2_mask   <= d2_next;
            err_q     <= err_next;
            err_row_q <= err_row_next;
            row_cnt   <= 3'd1;
            state     <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (done) begin
            col_mask  <= col_next;
            d1_mask   <= d1_next;
            d2_mask   <= d2_next;
            err_q     <= err_next;
            err_row_q <= err_row_next;
            if (row_cnt == 3'd7) begin
              row_cnt <= 3'd0;
              state   <= ST_REPORT;
            end else begin
              row_cnt <= row_cnt + 3'd1;
            end
          end else begin
            // Short board: the fragment verdict replaces any earlier error.
            err_q     <= EQ_FRAGMENT;
            err_row_q <= row_cnt;
            row_cnt   <= 3'd0;
            state     <= ST_REPORT;
          end
        end

        ST_REPORT: begin
          check_valid <= 1'b1;
          check_ok    <= (err_q == EQ_OK);
          err_code    <= err_q;
          err_row     <= err_row_q;
          board_count <= sat_inc8(board_count);
          if (err_q == EQ_OK) pass_count <= sat_inc8(pass_count);
          if (done) begin
            col_mask  <= col_next;
            d1_mask   <= d1_next;
            d2_mask   <= d2_next;
            err_q     <= err_next;
            err_row_q <= err_row_next;
            row_cnt   <= 3'd1;
            state     <= ST_COLLECT;
          end else begin
            col_mask  <= '0;
            d1_mask   <= '0;
            d2_mask   <= '0;
            err_q     <= EQ_OK;
            err_row_q <= 3'd0;
            row_cnt   <= 3'd0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eight_queen_checker.sv
// Purpose: randomized scoreboard bench for eight_queen_checker.
// Latency: expected verdict due one edge after the edge that completes a board.
// Backpressure: none; rows are driven freely on done.
module tb_eight_queen_checker;

  logic       clk = 1'b0;
  logic       user_reset = 1'b1;
  logic       done = 1'b0;
  logic [7:0] out_bus = 8'd0;
  logic       check_valid;
  logic       check_ok;
  logic [2:0] err_code;
  logic [2:0] err_row;
  logic       busy;
  logic [7:0] board_count;
  logic [7:0] pass_count;

  always #5 clk = ~clk;

  eight_queen_checker #(.ROWS(8)) dut (
    .clk         (clk),
    .user_reset  (user_reset),
    .done        (done),
    .out_bus     (out_bus),
    .check_valid (check_valid),
    .check_ok    (check_ok),
    .err_code    (err_code),
    .err_row     (err_row),
    .busy        (busy),
    .board_count (board_count),
    .pass_count  (pass_count)
  );

  typedef struct {
    int         cyc;
    logic       ok;
    logic [2:0] code;
    logic [2:0] row;
    logic [7:0] bc;
    logic [7:0] pc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] cur[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         mbc = 0;
  int         mpc = 0;

  logic [7:0] legal_a [8] = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
  logic [7:0] legal_b [8] = '{8'h01, 8'h20, 8'h80, 8'h04, 8'h40, 8'h08, 8'h02, 8'h10};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int col_of(input logic [7:0] b);
    for (int k = 0; k < 8; k++) if (b[k]) return k;
    return -1;
  endfunction

  // Board-level rules: a row errs if it is not exactly one queen, shares a
  // column with an earlier queen, or sits on a diagonal of an earlier queen.
  function automatic void judge(output logic [2:0] code, output logic [2:0] row);
    code = 3'd0;
    row  = 3'd0;
    for (int i = 0; i < cur.size(); i++) begin
      int e;
      e = 0;
      if ($countones(cur[i]) != 1) begin
        e = 1;
      end else begin
        bit ch;
        bit dh;
        int ci;
        ch = 0;
        dh = 0;
        ci = col_of(cur[i]);
        for (int j = 0; j < i; j++) begin
          if ($countones(cur[j]) == 1) begin
            int cj;
            cj = col_of(cur[j]);
            if (cj == ci) ch = 1;
            else if ((i - j) == (ci - cj) || (i - j) == (cj - ci)) dh = 1;
          end
        end
        e = ch ? 2 : (dh ? 3 : 0);
      end
      if (code == 3'd0 && e != 0) begin
        code = e[2:0];
        row  = i[2:0];
      end
    end
  endfunction

  task automatic finish_board(input logic [2:0] code, input logic [2:0] row, input int e);
    exp_t x;
    if (mbc < 255) mbc++;
    if (code == 3'd0 && mpc < 255) mpc++;
    x.cyc  = e + 2;
    x.ok   = (code == 3'd0);
    x.code = code;
    x.row  = row;
    x.bc   = mbc[7:0];
    x.pc   = mpc[7:0];
    sb.push_back(x);
    cur.delete();
  endtask

  task automatic send_row(input logic [7:0] b);
    int e;
    logic [2:0] code;
    logic [2:0] row;
    @(negedge clk);
    done    = 1'b1;
    out_bus = b;
    @(posedge clk);
    e = cyc;
    cur.push_back(b);
    if (cur.size() == 8) begin
      judge(code, row);
      finish_board(code, row, e);
    end
  endtask

  task automatic idle(input int n);
    int e;
    int sz;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      done    = 1'b0;
      out_bus = 8'($urandom);
      @(posedge clk);
      e = cyc;
      sz = cur.size();
      if (sz != 0) finish_board(3'd4, 3'(sz % 8), e);
    end
  endtask

  task automatic send_legal(input bit which);
    for (int i = 0; i < 8; i++) send_row(which ? legal_b[i] : legal_a[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_check_valid"}, check_valid, 0);
    check({tag, "_check_ok"}, check_ok, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_err_row"}, err_row, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_board_count"}, board_count, 0);
    check({tag, "_pass_count"}, pass_count, 0);
  endtask

  // Monitor: busy tracks a partially collected board; every verdict must
  // match the oldest expected one, on the expected cycle.
  always @(negedge clk) begin
    if (!user_reset) begin
      check("busy", busy, (cur.size() != 0) ? 1 : 0);
      if (check_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_verdict actual=check_valid required=no verdict (t=%0t)", $time);
        end else begin
          exp_t x;
          x = sb.pop_front();
          check("verdict_cycle", cyc, x.cyc);
          check("check_ok", check_ok, x.ok);
          check("err_code", err_code, x.code);
          check("err_row", err_row, x.row);
          check("board_count", board_count, x.bc);
          check("pass_count", pass_count, x.pc);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    user_reset = 1'b0;

    // Legal board, then column, diagonal and one-hot errors with later junk.
    send_legal(0);
    idle(3);
    for (int i = 0; i < 8; i++) send_row(8'h01);
    idle(3);
    @(negedge clk);
    check("hold_check_valid_low", check_valid, 0);
    check("hold_err_code", err_code, 2);
    send_row(8'h01);
    send_row(8'h02);
    for (int i = 0; i < 6; i++) send_row(8'($urandom));
    idle(2);
    send_row(8'h03);
    for (int i = 0; i < 7; i++) send_row(8'($urandom));
    idle(2);

    // Fragment after 5 rows.
    for (int i = 0; i < 5; i++) send_row(legal_a[i]);
    idle(3);

    // Back-to-back boards, then a 9-row burst (9th row is a new board).
    send_legal(0);
    send_legal(1);
    idle(2);
    send_legal(1);
    send_row(legal_a[0]);
    idle(2);

    // Reset mid-board: no verdict, everything back to zero.
    for (int i = 0; i < 4; i++) send_row(legal_a[i]);
    @(negedge clk);
    user_reset = 1'b1;
    done = 1'b0;
    cur.delete();
    sb.delete();
    mbc = 0;
    mpc = 0;
    @(negedge clk);
    check_reset_outputs("midreset");
    user_reset = 1'b0;
    send_legal(0);
    idle(2);

    // Random mix of legal, permuted, junk and short boards.
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: for (int i = 0; i < 8; i++) send_row(8'h01 << $urandom_range(0, 7));
        1: for (int i = 0; i < 8; i++)
             send_row(($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7)));
        2: begin
             int len;
             len = $urandom_range(1, 7);
             for (int i = 0; i < len; i++) send_row(8'h01 << $urandom_range(0, 7));
             idle($urandom_range(1, 2));
           end
        default: send_legal($urandom_range(0, 1) == 1);
      endcase
      idle($urandom_range(0, 2));
    end
    idle(2);

    // Saturation: 256 legal boards streamed back to back.
    for (int n = 0; n < 256; n++) send_legal(n[0]);
    idle(4);
    @(negedge clk);
    check("sat_board_count", board_count, 255);
    check("sat_pass_count", pass_count, 255);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eight_queen_checker.md
# eight_queen_checker

Consumer-side reader for the `eight_queen` solver's result stream. It samples `out_bus` on every cycle `done` is high, assembles 8 one-hot row bytes into a board, and checks the board incrementally as a legal 8-queens placement. Per board it reports one pass/fail verdict with an error code, plus running board and pass counts. It sits beside the solver in the top-level and serves as the on-chip self-check used by the solver benches.

## Interface
- `ROWS`, 8: board dimension. Fixed at 8; the parameter documents widths only.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `user_reset`  in  1  asynchronous, active-high reset.
- `done`  in  1  solver strobe. `out_bus` holds a valid row byte in every cycle `done` is high.
- `out_bus`  in  8  row byte, row 0 first. Bit c set means a queen in column c.
- `check_valid`  out  1  one-cycle pulse: the verdict outputs are valid.
- `check_ok`  out  1  board legal; meaningful only when `check_valid` is high.
- `err_code`  out  3  first error: 000 OK, 001 NOT_ONE_HOT, 010 COLUMN, 011 DIAGONAL, 100 FRAGMENT.
- `err_row`  out  3  row index where the first error was found. For FRAGMENT, the count of rows received, modulo 8.
- `busy`  out  1  high while a board is partially collected.
- `board_count`  out  8  boards reported; saturates at 255.
- `pass_count`  out  8  boards reported with `check_ok`; saturates at 255.

## Operation
- Each accepted row r with byte b is checked in order:
  - not one-hot (b == 0 or more than one bit set) → NOT_ONE_HOT;
  - otherwise c = index of the set bit; `col_mask[c]` already set → COLUMN;
  - `d1_mask[r+c]` or `d2_mask[r-c+7]` already set → DIAGONAL;
  - then set `col_mask[c]`, `d1_mask[r+c]` and `d2_mask[r-c+7]`.
- Mask widths: `col_mask` is 8 bits; `d1_mask` and `d2_mask` are 15 bits. r and c are 3 bits; r+c and r-c+7 are computed at 4 bits without overflow.
- NOT_ONE_HOT rows do not update any mask.
- Errors are sticky: only the first error (code and row) is latched. Remaining rows are still consumed.
- FSM:
  - IDLE: when `done`=1, process row 0, set `row_cnt`=1, go to COLLECT.
  - COLLECT, `done`=1: process row `row_cnt`. If `row_cnt`==7, go to REPORT; otherwise increment `row_cnt`.
  - COLLECT, `done`=0: go to REPORT with err_code FRAGMENT and `err_row`=`row_cnt`. FRAGMENT overrides any earlier latched error.
  - REPORT: pulse `check_valid` for one cycle, update the counters, and clear the masks and sticky error. If `done`=1 in this cycle, it is row 0 of the next board (go to COLLECT, `row_cnt`=1); otherwise go to IDLE.
- `check_ok` = (err_code == 000).
- `pass_count` increments only when `check_ok` is high.
- `busy` = (state == COLLECT).

## Timing
- Reset values: all outputs 0, state IDLE, masks 0, sticky error cleared.
- Latency: the 8th row is sampled at edge k; `check_valid`, `check_ok`, `err_code` and `err_row` are high/valid for the cycle after edge k+1.
- Verdict outputs hold their values until the next REPORT. Only `check_valid` pulses.
- Counters update on the same edge that raises `check_valid`.
- Back-to-back boards: `done` held high for 16 cycles gives two verdicts with no lost row. The REPORT cycle accepts row 0 of the next board.
- `done` high beyond 8 rows: rows 9 onward start a new board.
- Reset asserted mid-board: immediate return to reset values. No verdict is issued for the aborted board.
- Counter saturation: at 255 the counters hold; `check_valid` still pulses.

## Structure
- A shared package `eight_queen_pkg` holds:
  - the err_code constants (`EQ_OK`, `EQ_NOT_ONE_HOT`, `EQ_COLUMN`, `EQ_DIAGONAL`, `EQ_FRAGMENT`);
  - the FSM state encoding;
  - `ROWS` = 8 and the diagonal mask width 15.
- One sub-module, `onehot_encode8`: combinational 8→3 index plus an `is_onehot` flag, reusable by the solver.

## Test plan
- Legal board 01,10,80,20,04,40,02,08 on 8 consecutive `done` cycles → `check_valid` pulse, `check_ok`=1, `err_code`=000, `board_count`=1, `pass_count`=1.
- Rows 01,01,… (8 rows) → `err_code`=010, `err_row`=1, `check_ok`=0, `pass_count`=0.
- Rows 01,02,… → `err_code`=011, `err_row`=1. Rows 03,… → `err_code`=001, `err_row`=0. In each case the first error is kept despite later errors.
- `done` high for 5 cycles then low → `check_valid` one cycle after `done` falls, `err_code`=100, `err_row`=5, `busy` low afterwards.
- `done` held 16 cycles with the legal board twice → two verdicts 8 cycles apart, both OK, `board_count`=2.
- `user_reset` pulsed after 4 rows → no `check_valid`, all outputs 0. The next 8 legal rows → OK. 256 legal boards → counters saturate at 255.
